reaction_timer: RTL

- Sits directly downstream of the LED delay stage (the `lighter` block).
- Drives that stage's `enable` input and consumes its LED output.
- Measures player reaction time in milliseconds, from LED-on to the button press.
- Flags false starts and timeouts; tracks the best (lowest) time since reset. Results feed the display stage.

---
 rtl/reaction_pkg.sv | 23 ++
 rtl/ms_tick.sv | 33 +++
 rtl/reaction_timer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and defaults for the reaction timer block.
package reaction_pkg;

  // 50 MHz system clock divided down to a 1 ms tick.
  localparam int TICK_DIV_DEF = 50000;
  // Largest value a 4-digit display can show; also the timeout point.
  localparam int MAX_MS_DEF   = 9999;

  // Round state. The encoding is fixed so a checker can decode it.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    TIMING = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  // True while a round is live and the delay stage should run.
  function automatic logic is_active(input state_t s);
    return (s == ARMED) || (s == TIMING);
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 while run is high and
// emits a one-cycle tick on the last count. clear forces the phase to 0.
module ms_tick
  import reaction_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Phase counter; clear wins over run so entry always starts at phase 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = run && !clear && (count == LAST);

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: arms the LED delay stage, times LED-on to button press
// in milliseconds, flags false starts and timeouts, and keeps the best
// (lowest) genuine time since reset.
//
// Handshake note: there is no valid/ready pair here. start is a one-cycle
// command accepted in any state; led_on and button are level inputs;
// valid/false_start/timeout are result levels held until the next start.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int MAX_MS   = MAX_MS_DEF,
  parameter int W        = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         led_on,
  input  logic         button,
  output logic         lighter_en,
  output logic [W-1:0] time_ms,
  output logic [W-1:0] best_ms,
  output logic         valid,
  output logic         false_start,
  output logic         timeout,
  output logic         busy
);

  localparam logic [W-1:0] MAX_VAL = W'(MAX_MS);

  state_t       state;
  state_t       state_next;
  logic [W-1:0] time_next;
  logic [W-1:0] best_next;
  logic         valid_next;
  logic         false_start_next;
  logic         timeout_next;

  logic sync1;
  logic sync2;
  logic sync_prev;
  logic press;
  logic tick;

  // Two-flop synchronizer for the raw button plus the edge-detect history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= button;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // A press is the first cycle the synchronized button is seen high.
  assign press = sync2 & ~sync_prev;

  // Prescaler runs only while timing and restarts its phase on every entry.
  ms_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_ms_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state != TIMING),
    .run   (state == TIMING),
    .tick  (tick)
  );

  // Round control: start overrides everything, then per-state events.
  // In TIMING a press beats an abort, and an abort beats a tick.
  always_comb begin
    state_next       = state;
    time_next        = time_ms;
    best_next        = best_ms;
    valid_next       = valid;
    false_start_next = false_start;
    timeout_next     = timeout;

    if (start) begin
      state_next       = ARMED;
      time_next        = '0;
      valid_next       = 1'b0;
      false_start_next = 1'b0;
      timeout_next     = 1'b0;
    end else begin
      case (state)
        ARMED: begin
          if (press) begin
            state_next       = FAULT;
            false_start_next = 1'b1;
          end else if (led_on) begin
            state_next = TIMING;
          end
        end
        TIMING: begin
          if (press) begin
            state_next = DONE;
            valid_next = 1'b1;
            if (time_ms < best_ms) begin
              best_next = time_ms;
            end
          end else if (!led_on) begin
            // Delay stage dropped the LED: abandon the round, keep the count.
            state_next = IDLE;
          end else if (tick) begin
            if (time_ms >= MAX_VAL - W'(1)) begin
              time_next    = MAX_VAL;
              timeout_next = 1'b1;
              state_next   = DONE;
            end else begin
              time_next = time_ms + W'(1);
            end
          end
        end
        default: begin
          // IDLE, DONE and FAULT wait for the next start.
        end
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      time_ms     <= '0;
      best_ms     <= MAX_VAL;
      valid       <= 1'b0;
      false_start <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      time_ms     <= time_next;
      best_ms     <= best_next;
      valid       <= valid_next;
      false_start <= false_start_next;
      timeout     <= timeout_next;
    end
  end

  // Enable trails the state by one cycle, so it drops the cycle after the
  // round leaves ARMED/TIMING and the delay stage then clears the LED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lighter_en <= 1'b0;
    end else begin
      lighter_en <= is_active(state);
    end
  end

  assign busy = is_active(state);

endmodule
